// File: rtl/call_register.sv
// call_register: latched hall/car call store for an elevator controller.
// Active-low push buttons are synchronised and edge-detected, so each press
// gives a single one-cycle event. Calls are held in flops until the car
// services the floor, and above/below/here/pending summaries are produced
// for the direction logic.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   hall_up_n  hall up buttons, 0 = pressed (top floor bit ignored)
//   hall_dn_n  hall down buttons, 0 = pressed (ground floor bit ignored)
//   car_n      in-car floor buttons, 0 = pressed
//   position   current car floor, 0 = ground
//   moving     car is between floors
//   door_open  door is open at position
//   head       travel direction, 1 = up, 0 = down
//   req_up     latched hall-up calls
//   req_dn     latched hall-down calls
//   req_car    latched car calls
//   any_above  any call at a floor above position (combinational)
//   any_below  any call at a floor below position (combinational)
//   any_here   any call at position (combinational)
//   pending    any call anywhere (combinational)
module call_register #(
    parameter int unsigned FLOORS = 4,
    parameter int unsigned FW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] hall_up_n,
    input  logic [FLOORS-1:0] hall_dn_n,
    input  logic [FLOORS-1:0] car_n,
    input  logic [FW-1:0]     position,
    input  logic              moving,
    input  logic              door_open,
    input  logic              head,
    output logic [FLOORS-1:0] req_up,
    output logic [FLOORS-1:0] req_dn,
    output logic [FLOORS-1:0] req_car,
    output logic              any_above,
    output logic              any_below,
    output logic              any_here,
    output logic              pending
);

    // All three button groups share one synchroniser/edge-detect pipeline.
    localparam int unsigned BW = 3 * FLOORS;

    // The top floor has no up button and the ground floor no down button.
    localparam logic [FLOORS-1:0] UP_VALID = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [BW-1:0]     btn_n;
    logic [BW-1:0]     sync_a;
    logic [BW-1:0]     sync_b;
    logic [BW-1:0]     sync_d;
    logic [BW-1:0]     press;

    logic [FLOORS-1:0] ev_up;
    logic [FLOORS-1:0] ev_dn;
    logic [FLOORS-1:0] ev_car;

    logic [FLOORS-1:0] svc;
    logic [FLOORS-1:0] clr_up;
    logic [FLOORS-1:0] clr_dn;
    logic [FLOORS-1:0] clr_car;

    logic [FLOORS-1:0] up_nxt;
    logic [FLOORS-1:0] dn_nxt;
    logic [FLOORS-1:0] car_nxt;

    logic [FLOORS-1:0] has_call;

    assign btn_n = {car_n, hall_dn_n, hall_up_n};

    // Two-flop synchroniser plus a delay flop for falling-edge detection;
    // everything resets to released so reset itself never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '1;
            sync_b <= '1;
            sync_d <= '1;
        end else begin
            sync_a <= btn_n;
            sync_b <= sync_a;
            sync_d <= sync_b;
        end
    end

    // Press event: synchronised level went 1 -> 0 this cycle.
    assign press  = sync_d & ~sync_b;
    assign ev_up  = press[FLOORS-1:0] & UP_VALID;
    assign ev_dn  = press[2*FLOORS-1:FLOORS] & DN_VALID;
    assign ev_car = press[3*FLOORS-1:2*FLOORS];

    // Per-floor summary of current latch state.
    assign has_call = req_up | req_dn | req_car;
    assign pending  = |has_call;

    // Position-relative summaries; an out-of-range position naturally gives
    // above = 0, below = OR of all floors, here = 0.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        any_here  = 1'b0;
        for (int unsigned f = 0; f < FLOORS; f++) begin
            if (FW'(f) > position) begin
                any_above = any_above | has_call[f];
            end
            if (FW'(f) < position) begin
                any_below = any_below | has_call[f];
            end
            if (FW'(f) == position) begin
                any_here = any_here | has_call[f];
            end
        end
    end

    // Service condition: stopped with the door open at floor f.
    always_comb begin
        svc = '0;
        for (int unsigned f = 0; f < FLOORS; f++) begin
            svc[f] = ~moving & door_open & (position == FW'(f));
        end
    end

    // Served floor drops its car call and the call in the travel direction;
    // the opposite hall call also drops when nothing remains ahead (reversal).
    assign clr_car = svc;
    assign clr_up  = svc & {FLOORS{head | ~any_below}};
    assign clr_dn  = svc & {FLOORS{~head | ~any_above}};

    // Clear dominates set, which also covers press suppression at a served floor.
    assign up_nxt  = (req_up  | ev_up)  & ~clr_up  & UP_VALID;
    assign dn_nxt  = (req_dn  | ev_dn)  & ~clr_dn  & DN_VALID;
    assign car_nxt = (req_car | ev_car) & ~clr_car;

    // Call latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_up  <= '0;
            req_dn  <= '0;
            req_car <= '0;
        end else begin
            req_up  <= up_nxt;
            req_dn  <= dn_nxt;
            req_car <= car_nxt;
        end
    end

endmodule

// File: tb/tb_call_register.sv
// Directed, table-driven bench for call_register: a 4-floor instance runs the
// vector table and reset sequences; 8-floor and 3-floor instances cover wider
// parameters and an out-of-range position.
module tb_call_register;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-floor instance
    logic [3:0] hu4_n = 4'hF, hd4_n = 4'hF, car4_n = 4'hF;
    logic [1:0] pos4 = 2'd0;
    logic       mov4 = 1'b1, door4 = 1'b0, head4 = 1'b1;
    logic [3:0] up4, dn4, rc4;
    logic       ab4, be4, he4, pe4;

    call_register #(.FLOORS(4), .FW(2)) dut4 (
        .clk(clk), .rst(rst),
        .hall_up_n(hu4_n), .hall_dn_n(hd4_n), .car_n(car4_n),
        .position(pos4), .moving(mov4), .door_open(door4), .head(head4),
        .req_up(up4), .req_dn(dn4), .req_car(rc4),
        .any_above(ab4), .any_below(be4), .any_here(he4), .pending(pe4)
    );

    // 8-floor instance
    logic [7:0] hu8_n = 8'hFF, hd8_n = 8'hFF, car8_n = 8'hFF;
    logic [2:0] pos8 = 3'd0;
    logic       mov8 = 1'b1, door8 = 1'b0, head8 = 1'b1;
    logic [7:0] up8, dn8, rc8;
    logic       ab8, be8, he8, pe8;

    call_register #(.FLOORS(8), .FW(3)) dut8 (
        .clk(clk), .rst(rst),
        .hall_up_n(hu8_n), .hall_dn_n(hd8_n), .car_n(car8_n),
        .position(pos8), .moving(mov8), .door_open(door8), .head(head8),
        .req_up(up8), .req_dn(dn8), .req_car(rc8),
        .any_above(ab8), .any_below(be8), .any_here(he8), .pending(pe8)
    );

    // 3-floor instance, position field can exceed the floor count
    logic [2:0] hu3_n = 3'h7, hd3_n = 3'h7, car3_n = 3'h7;
    logic [1:0] pos3 = 2'd0;
    logic       mov3 = 1'b1, door3 = 1'b0, head3 = 1'b1;
    logic [2:0] up3, dn3, rc3;
    logic       ab3, be3, he3, pe3;

    call_register #(.FLOORS(3), .FW(2)) dut3 (
        .clk(clk), .rst(rst),
        .hall_up_n(hu3_n), .hall_dn_n(hd3_n), .car_n(car3_n),
        .position(pos3), .moving(mov3), .door_open(door3), .head(head3),
        .req_up(up3), .req_dn(dn3), .req_car(rc3),
        .any_above(ab3), .any_below(be3), .any_here(he3), .pending(pe3)
    );

    typedef struct {
        logic [3:0] up_n;
        logic [3:0] dn_n;
        logic [3:0] car_n;
        logic [1:0] pos;
        logic       mov;
        logic       door;
        logic       head;
        int         cyc;
        logic [3:0] e_up;
        logic [3:0] e_dn;
        logic [3:0] e_car;
        logic       e_ab;
        logic       e_be;
        logic       e_he;
        logic       e_pe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for check/drive.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk4(input string tag, input logic [3:0] eu, input logic [3:0] ed,
                        input logic [3:0] ec, input logic ea, input logic eb,
                        input logic eh, input logic ep);
        chk({tag, " req_up"},    8'(up4), 8'(eu));
        chk({tag, " req_dn"},    8'(dn4), 8'(ed));
        chk({tag, " req_car"},   8'(rc4), 8'(ec));
        chk({tag, " any_above"}, 8'(ab4), 8'(ea));
        chk({tag, " any_below"}, 8'(be4), 8'(eb));
        chk({tag, " any_here"},  8'(he4), 8'(eh));
        chk({tag, " pending"},   8'(pe4), 8'(ep));
    endtask

    initial begin
        // up_n, dn_n, car_n, pos, mov, door, head, cyc, e_up, e_dn, e_car, ab, be, he, pe
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd0, 1'b1, 1'b0, 1'b1, 3,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 4'hB, 2'd0, 1'b1, 1'b0, 1'b1, 2,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 4'hB, 2'd0, 1'b1, 1'b0, 1'b1, 1,  4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd0, 1'b1, 1'b0, 1'b1, 3,  4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'hD, 4'hD, 4'h7, 2'd0, 1'b1, 1'b0, 1'b1, 3,  4'h2, 4'h2, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd1, 1'b1, 1'b0, 1'b1, 3,  4'h2, 4'h2, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd1, 1'b0, 1'b1, 1'b1, 1,  4'h0, 4'h2, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd2, 1'b0, 1'b1, 1'b1, 1,  4'h0, 4'h2, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd3, 1'b0, 1'b1, 1'b1, 1,  4'h0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd1, 1'b0, 1'b1, 1'b1, 1,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hB, 4'hF, 2'd2, 1'b0, 1'b1, 1'b0, 3,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd2, 1'b1, 1'b0, 1'b0, 3,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hB, 4'hF, 4'hF, 2'd2, 1'b0, 1'b1, 1'b0, 3,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd2, 1'b1, 1'b0, 1'b0, 3,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 4'hE, 2'd2, 1'b1, 1'b0, 1'b0, 3,  4'h0, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd2, 1'b1, 1'b0, 1'b0, 1,  4'h0, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{4'hB, 4'hF, 4'hF, 2'd2, 1'b0, 1'b1, 1'b0, 3,  4'h4, 4'h0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0, 1,  4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd2, 1'b0, 1'b1, 1'b0, 1,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'h7, 4'hE, 4'hD, 2'd0, 1'b1, 1'b0, 1'b1, 20, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'h7, 4'hE, 4'hD, 2'd1, 1'b0, 1'b1, 1'b1, 1,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'h7, 4'hE, 4'hD, 2'd1, 1'b1, 1'b0, 1'b1, 10, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 2'd1, 1'b1, 1'b0, 1'b1, 3,  4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Reset state
        step(2);
        chk4("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1);

        // Vector table on the 4-floor instance
        foreach (tbl[i]) begin
            hu4_n  = tbl[i].up_n;
            hd4_n  = tbl[i].dn_n;
            car4_n = tbl[i].car_n;
            pos4   = tbl[i].pos;
            mov4   = tbl[i].mov;
            door4  = tbl[i].door;
            head4  = tbl[i].head;
            step(tbl[i].cyc);
            chk4($sformatf("v%0d", i), tbl[i].e_up, tbl[i].e_dn, tbl[i].e_car,
                 tbl[i].e_ab, tbl[i].e_be, tbl[i].e_he, tbl[i].e_pe);
        end

        // Mid-run asynchronous reset with req_car = 1010
        pos4 = 2'd0; mov4 = 1'b1; door4 = 1'b0; head4 = 1'b1;
        car4_n = 4'b0101;
        step(3);
        car4_n = 4'hF;
        step(1);
        chk("pre-reset req_car", 8'(rc4), 8'h0A);
        #2 rst = 1'b0;
        #1 chk4("async reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(5);
        chk4("post-reset idle", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Button held through reset release gives one event afterwards
        rst = 1'b0;
        car4_n = 4'b1011;
        step(2);
        rst = 1'b1;
        step(2);
        chk("held-thru-reset early", 8'(rc4), 8'h00);
        step(1);
        chk("held-thru-reset latch", 8'(rc4), 8'h04);
        car4_n = 4'hF;

        // Wider instance: all car buttons, then serve top floor
        car8_n = 8'h00;
        // Narrow instance parked at an out-of-range position with door open
        hu3_n = 3'b000; hd3_n = 3'b000; car3_n = 3'b000;
        pos3 = 2'd3; mov3 = 1'b0; door3 = 1'b1; head3 = 1'b1;
        step(3);
        chk("f8 all car", 8'(rc8), 8'hFF);
        chk("f3 req_car", 8'(rc3), 8'h07);
        chk("f3 req_up",  8'(up3), 8'h03);
        chk("f3 req_dn",  8'(dn3), 8'h06);
        chk("f3 any_above", 8'(ab3), 8'h00);
        chk("f3 any_below", 8'(be3), 8'h01);
        chk("f3 any_here",  8'(he3), 8'h00);
        chk("f3 pending",   8'(pe3), 8'h01);
        car8_n = 8'hFF;
        pos8 = 3'd7; mov8 = 1'b0; door8 = 1'b1; head8 = 1'b1;
        step(1);
        chk("f8 top serve req_car", 8'(rc8), 8'h7F);
        chk("f8 any_above", 8'(ab8), 8'h00);
        chk("f8 any_below", 8'(be8), 8'h01);
        chk("f8 any_here",  8'(he8), 8'h00);
        chk("f8 pending",   8'(pe8), 8'h01);
        chk("f8 req_up",    8'(up8), 8'h00);
        chk("f3 no clear out of range", 8'(rc3), 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
